// File: rtl/u_back_substitution.sv
// Back substitution for the OMP-DRI datapath: solves U*x = z for n = current_i+1 and
// streams each coefficient into the X BRAM, highest index first.
module u_back_substitution #(
  parameter int DATA_W  = 32,
  parameter int FRAC    = 16,
  parameter int MAX_I_W = 5,
  parameter int GUARD   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_c,
  input  logic [MAX_I_W-1:0]     current_i,
  output logic [2*MAX_I_W-1:0]   u_addr,
  input  logic [DATA_W-1:0]      u_rdata,
  output logic [MAX_I_W-1:0]     z_addr,
  input  logic [DATA_W-1:0]      z_rdata,
  output logic                   x_we,
  output logic [MAX_I_W-1:0]     x_addr,
  output logic [DATA_W-1:0]      x_wdata,
  output logic                   busy,
  output logic                   done_c,
  output logic                   div_err
);

  localparam int ACC_W = DATA_W + FRAC + GUARD;
  localparam int DIV_N = DATA_W + FRAC;
  localparam int REM_W = DATA_W + 1;
  localparam int CNT_W = $clog2(DIV_N);
  localparam int NMAX  = 1 << MAX_I_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_N - 1);

  typedef enum logic [3:0] {
    IDLE, Z_RD, Z_LD, MAC_RD, MAC_ACC, D_RD, DIV, WR, DONE
  } state_t;

  state_t                     r_state, w_next;
  logic [MAX_I_W:0]           r_n, r_j;
  logic [MAX_I_W-1:0]         r_k;
  logic signed [ACC_W-1:0]    r_acc;
  logic [REM_W-1:0]           r_div, r_rem;
  logic [DIV_N-1:0]           r_dlo, r_quo;
  logic [CNT_W-1:0]           r_cnt;
  logic                       r_neg, r_ovf, r_dz, r_drd, r_div_err;
  logic signed [DATA_W-1:0]   r_xreg [NMAX];

  logic [MAX_I_W:0]           w_k_inc, w_j_inc;
  logic signed [2*DATA_W-1:0] w_prod;
  logic [REM_W-1:0]           w_uabs;
  logic [ACC_W-1:0]           w_acc_abs;
  logic                       w_ovf;
  logic [REM_W:0]             w_trial;
  logic                       w_fit;
  logic [REM_W-1:0]           w_rem_next;
  logic                       w_pos_ovf, w_neg_ovf;
  logic signed [DATA_W-1:0]   w_q;

  assign w_k_inc   = {1'b0, r_k} + 1'b1;
  assign w_j_inc   = r_j + 1'b1;
  assign w_prod    = $signed(u_rdata) * r_xreg[r_j[MAX_I_W-1:0]];
  assign w_uabs    = u_rdata[DATA_W-1] ? (REM_W'(0) - {1'b1, u_rdata}) : {1'b0, u_rdata};
  assign w_acc_abs = r_acc[ACC_W-1] ? -$unsigned(r_acc) : $unsigned(r_acc);
  // Quotient would need more than DIV_N bits: it saturates anyway, so skip the long division.
  assign w_ovf     = (REM_W + DATA_W)'(w_acc_abs) >= {w_uabs, {DATA_W{1'b0}}};

  assign w_trial    = {r_rem, r_dlo[DIV_N-1]};
  assign w_fit      = w_trial >= {1'b0, r_div};
  assign w_rem_next = w_fit ? REM_W'(w_trial - {1'b0, r_div}) : REM_W'(w_trial);

  assign w_pos_ovf = |r_quo[DIV_N-1:DATA_W-1];
  assign w_neg_ovf = (|r_quo[DIV_N-1:DATA_W]) || (r_quo[DATA_W-1] && (|r_quo[DATA_W-2:0]));

  always_comb begin
    w_q = '0;
    if (r_dz) begin
      w_q = '0;
    end else if (!r_neg) begin
      w_q = (w_pos_ovf || r_ovf) ? {1'b0, {(DATA_W-1){1'b1}}} : r_quo[DATA_W-1:0];
    end else begin
      w_q = (w_neg_ovf || r_ovf) ? {1'b1, {(DATA_W-1){1'b0}}} : -r_quo[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start_c) w_next = Z_RD;
      Z_RD:    w_next = Z_LD;
      Z_LD:    w_next = (w_k_inc < r_n) ? MAC_RD : D_RD;
      MAC_RD:  w_next = MAC_ACC;
      MAC_ACC: w_next = (w_j_inc < r_n) ? MAC_RD : D_RD;
      D_RD:    if (r_drd) w_next = DIV;
      DIV:     if (r_cnt == CNT_LAST) w_next = WR;
      WR:      w_next = (r_k == '0) ? DONE : Z_RD;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    u_addr  = '0;
    z_addr  = '0;
    x_we    = 1'b0;
    x_addr  = '0;
    x_wdata = '0;
    case (r_state)
      Z_RD:   z_addr = r_k;
      MAC_RD: u_addr = {r_j[MAX_I_W-1:0], r_k};
      D_RD:   u_addr = {r_k, r_k};
      WR: begin
        x_we    = 1'b1;
        x_addr  = r_k;
        x_wdata = w_q;
      end
      default: ;
    endcase
  end

  assign busy    = (r_state != IDLE) && (r_state != DONE);
  assign done_c  = (r_state == DONE);
  assign div_err = r_div_err;

  // Divider operands are prepared on the second D_RD cycle, when U[k,k] is on u_rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n       <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_acc     <= '0;
      r_div     <= '0;
      r_rem     <= '0;
      r_dlo     <= '0;
      r_quo     <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_ovf     <= 1'b0;
      r_dz      <= 1'b0;
      r_drd     <= 1'b0;
      r_div_err <= 1'b0;
    end else begin
      r_drd <= (r_state == D_RD) ? ~r_drd : 1'b0;
      case (r_state)
        IDLE: if (start_c) begin
          r_n       <= {1'b0, current_i} + 1'b1;
          r_k       <= current_i;
          r_div_err <= 1'b0;
        end
        Z_LD: begin
          r_acc <= ACC_W'($signed(z_rdata));
          r_j   <= w_k_inc;
        end
        MAC_ACC: begin
          r_acc <= r_acc - ACC_W'(w_prod >>> FRAC);
          r_j   <= w_j_inc;
        end
        D_RD: if (r_drd) begin
          r_div <= w_uabs;
          r_dz  <= (u_rdata == '0);
          r_neg <= r_acc[ACC_W-1] ^ u_rdata[DATA_W-1];
          r_ovf <= w_ovf;
          r_rem <= REM_W'(w_acc_abs[ACC_W-1:DATA_W]);
          r_dlo <= {w_acc_abs[DATA_W-1:0], {FRAC{1'b0}}};
          r_quo <= '0;
          r_cnt <= '0;
          if (u_rdata == '0) r_div_err <= 1'b1;
        end
        DIV: begin
          r_rem <= w_rem_next;
          r_dlo <= r_dlo << 1;
          r_quo <= {r_quo[DIV_N-2:0], w_fit};
          r_cnt <= r_cnt + 1'b1;
        end
        WR: if (r_k != '0) r_k <= r_k - 1'b1;
        default: ;
      endcase
    end
  end

  // Solved coefficients feed later rows; deliberately not reset.
  always_ff @(posedge clk) begin
    if (r_state == WR) r_xreg[r_k] <= w_q;
  end

endmodule

// File: tb/tb_u_back_substitution.sv
// Self-checking bench for u_back_substitution: exact wide-arithmetic reference solve,
// cycle-level compare of the write stream, busy, done_c and div_err.
`timescale 1ns/1ps
module tb_u_back_substitution;

  localparam int DATA_W  = 32;
  localparam int FRAC    = 16;
  localparam int MAX_I_W = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_c = 1'b0;
  logic [4:0]  current_i = '0;
  logic [9:0]  u_addr;
  logic [31:0] u_rdata = '0;
  logic [4:0]  z_addr;
  logic [31:0] z_rdata = '0;
  logic        x_we;
  logic [4:0]  x_addr;
  logic [31:0] x_wdata;
  logic        busy, done_c, div_err;

  u_back_substitution #(.DATA_W(DATA_W), .FRAC(FRAC), .MAX_I_W(MAX_I_W), .GUARD(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_c(start_c), .current_i(current_i),
    .u_addr(u_addr), .u_rdata(u_rdata), .z_addr(z_addr), .z_rdata(z_rdata),
    .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata),
    .busy(busy), .done_c(done_c), .div_err(div_err)
  );

  always #5 clk = ~clk;

  logic [31:0] uMem [1024];
  logic [31:0] zMem [32];
  always @(posedge clk) begin
    u_rdata <= uMem[u_addr];
    z_rdata <= zMem[z_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checkCount = 0;
  int failCount = 0;

  bit          runActive = 1'b0;
  bit          expDivErr = 1'b0;
  int          startCyc, doneCycExp, nWrites, wrIdx;
  int          expWeCyc [32];
  logic [4:0]  expAddr [32];
  logic [31:0] expData [32];

  int          weCnt, doneCnt, doneSeenCyc, capN;
  logic [4:0]  capAddr [32];
  logic [31:0] capData [32];
  bit          expWe, expBusy, expDone;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic setU(input int row, input int col, input logic [31:0] v);
    logic [4:0] r5, c5;
    r5 = 5'(row);
    c5 = 5'(col);
    uMem[{c5, r5}] = v;
  endtask

  function automatic logic [31:0] getU(input int row, input int col);
    logic [4:0] r5, c5;
    r5 = 5'(row);
    c5 = 5'(col);
    return uMem[{c5, r5}];
  endfunction

  task automatic clearMem();
    for (int a = 0; a < 1024; a++) uMem[a] = '0;
    for (int a = 0; a < 32; a++) zMem[a] = '0;
  endtask

  // Exact reference solve plus the expected cycle of every write and of done_c.
  task automatic computeModel(input int n);
    logic signed [127:0] acc, uu, xx, r, q;
    logic [31:0] xv [32];
    int t, idx;
    expDivErr = 1'b0;
    for (int k = n - 1; k >= 0; k--) begin
      acc = $signed(zMem[k]);
      for (int j = k + 1; j < n; j++) begin
        uu = $signed(getU(k, j));
        xx = $signed(xv[j]);
        acc = acc - ((uu * xx) >>> FRAC);
      end
      r = $signed(getU(k, k));
      if (r == 0) begin
        q = 0;
        expDivErr = 1'b1;
      end else begin
        q = (acc <<< FRAC) / r;
        if (q > 128'sh7FFFFFFF) q = 128'sh7FFFFFFF;
        else if (q < -128'sh80000000) q = -128'sh80000000;
      end
      xv[k] = q[31:0];
    end
    t = startCyc;
    idx = 0;
    for (int k = n - 1; k >= 0; k--) begin
      t += 53 + 2 * (n - 1 - k);
      expWeCyc[idx] = t;
      expAddr[idx]  = 5'(k);
      expData[idx]  = xv[k];
      idx++;
    end
    nWrites = n;
    wrIdx = 0;
    doneCycExp = t + 1;
  endtask

  always @(negedge clk) begin
    expWe   = runActive && (wrIdx < nWrites) && (cyc == expWeCyc[wrIdx]);
    expBusy = runActive && (cyc > startCyc) && (cyc < doneCycExp);
    expDone = runActive && (cyc == doneCycExp);
    checkOutput("x_we", 32'(x_we), 32'(expWe));
    checkOutput("busy", 32'(busy), 32'(expBusy));
    checkOutput("done_c", 32'(done_c), 32'(expDone));
    if (x_we) begin
      weCnt++;
      if (capN < 32) begin
        capAddr[capN] = x_addr;
        capData[capN] = x_wdata;
        capN++;
      end
    end
    if (done_c) begin
      doneCnt++;
      doneSeenCyc = cyc;
    end
    if (expWe) begin
      checkOutput("x_addr", 32'(x_addr), 32'(expAddr[wrIdx]));
      checkOutput("x_wdata", x_wdata, expData[wrIdx]);
      wrIdx++;
    end
    if (!runActive || expDone) checkOutput("div_err", 32'(div_err), 32'(expDivErr));
    if (expDone) runActive = 1'b0;
  end

  task automatic applyStimulus(input int n);
    @(posedge clk);
    #1;
    current_i = 5'(n - 1);
    start_c = 1'b1;
    startCyc = cyc;
    weCnt = 0;
    doneCnt = 0;
    capN = 0;
    doneSeenCyc = -1;
    computeModel(n);
    runActive = 1'b1;
    @(posedge clk);
    #1;
    start_c = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int w;
    w = 0;
    while (runActive && w < budget) begin
      @(posedge clk);
      w++;
    end
    if (runActive) begin
      checkCount++;
      failCount++;
      $display("[TB] FAIL run_timeout actual=still_running required=done_within_%0d", budget);
      runActive = 1'b0;
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_x_we"}, 32'(x_we), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done_c"}, 32'(done_c), 32'd0);
    checkOutput({tag, "_div_err"}, 32'(div_err), 32'd0);
    checkOutput({tag, "_u_addr"}, 32'(u_addr), 32'd0);
    checkOutput({tag, "_z_addr"}, 32'(z_addr), 32'd0);
    checkOutput({tag, "_x_addr"}, 32'(x_addr), 32'd0);
    checkOutput({tag, "_x_wdata"}, x_wdata, 32'd0);
  endtask

  // Diagonal in +-[0.5,4.0], off-diagonal in +-2.0, z in +-8.0; wide mode uses raw words.
  task automatic randomFill(input int n, input bit wide);
    int v;
    clearMem();
    for (int r = 0; r < n; r++) begin
      for (int c = r; c < n; c++) begin
        if (wide) begin
          setU(r, c, $urandom());
        end else if (c == r) begin
          v = int'($urandom_range(32768, 262144));
          if ($urandom_range(0, 1) == 1) v = -v;
          setU(r, c, 32'(v));
        end else begin
          v = int'($urandom_range(0, 262144)) - 131072;
          setU(r, c, 32'(v));
        end
      end
      if (wide) zMem[r] = $urandom();
      else begin
        v = int'($urandom_range(0, 1048576)) - 524288;
        zMem[r] = 32'(v);
      end
    end
  endtask

  initial begin
    int n;
    clearMem();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkIdleOutputs("reset");
    rst_n = 1'b1;

    clearMem();
    setU(0, 0, 32'h00020000);
    zMem[0] = 32'h00030000;
    applyStimulus(1);
    waitDone(200);
    checkOutput("t1_writes", 32'(capN), 32'd1);
    checkOutput("t1_x0", capData[0], 32'h00018000);
    checkOutput("t1_latency", 32'(doneSeenCyc - startCyc + 1), 32'd55);
    checkOutput("t1_div_err", 32'(div_err), 32'd0);

    clearMem();
    setU(0, 0, 32'h00020000);
    setU(0, 1, 32'h00010000);
    setU(1, 1, 32'h00040000);
    zMem[0] = 32'h00050000;
    zMem[1] = 32'h00080000;
    applyStimulus(2);
    waitDone(300);
    checkOutput("t2_first_addr", 32'(capAddr[0]), 32'd1);
    checkOutput("t2_x1", capData[0], 32'h00020000);
    checkOutput("t2_second_addr", 32'(capAddr[1]), 32'd0);
    checkOutput("t2_x0", capData[1], 32'h00018000);
    checkOutput("t2_latency", 32'(doneSeenCyc - startCyc + 1), 32'd110);

    clearMem();
    setU(0, 0, 32'hFFFE0000);
    zMem[0] = 32'h00030000;
    applyStimulus(1);
    waitDone(200);
    checkOutput("neg_x0", capData[0], 32'hFFFE8000);

    clearMem();
    setU(0, 0, 32'h00000001);
    zMem[0] = 32'h7FFF0000;
    applyStimulus(1);
    waitDone(200);
    checkOutput("sat_x0", capData[0], 32'h7FFFFFFF);

    clearMem();
    setU(0, 0, 32'h00020000);
    setU(0, 1, 32'h00010000);
    setU(1, 1, 32'h00000000);
    zMem[0] = 32'h00050000;
    zMem[1] = 32'h00080000;
    applyStimulus(2);
    waitDone(300);
    checkOutput("dz_x1", capData[0], 32'h00000000);
    checkOutput("dz_x0", capData[1], 32'h00028000);
    checkOutput("dz_div_err_held", 32'(div_err), 32'd1);

    randomFill(3, 1'b0);
    applyStimulus(3);
    checkOutput("div_err_cleared", 32'(div_err), 32'd0);
    while (cyc != startCyc + 10) begin
      @(posedge clk);
      #1;
    end
    start_c = 1'b1;
    current_i = 5'd7;
    @(posedge clk);
    #1;
    start_c = 1'b0;
    waitDone(500);
    checkOutput("midstart_we_pulses", 32'(weCnt), 32'd3);
    checkOutput("midstart_done_pulses", 32'(doneCnt), 32'd1);

    randomFill(3, 1'b0);
    applyStimulus(3);
    while (cyc != startCyc + 56) begin
      @(posedge clk);
      #1;
    end
    checkOutput("mac_u_addr", 32'(u_addr), 32'h041);
    #2;
    rst_n = 1'b0;
    runActive = 1'b0;
    expDivErr = 1'b0;
    #1;
    checkIdleOutputs("abort");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(3);
    waitDone(500);
    checkOutput("after_abort_we_pulses", 32'(weCnt), 32'd3);
    checkOutput("after_abort_done_pulses", 32'(doneCnt), 32'd1);

    for (int t = 0; t < 6; t++) begin
      n = int'($urandom_range(1, 8));
      randomFill(n, 1'b0);
      applyStimulus(n);
      waitDone(2000);
    end
    randomFill(32, 1'b0);
    applyStimulus(32);
    waitDone(4000);
    checkOutput("n32_we_pulses", 32'(weCnt), 32'd32);
    randomFill(5, 1'b1);
    applyStimulus(5);
    waitDone(1000);
    randomFill(2, 1'b1);
    applyStimulus(2);
    waitDone(500);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/u_back_substitution.md
Name: u_back_substitution

Overview:
Block C of the OMP-DRI datapath. It consumes the upper-triangular U BRAM written by Block B (MGS) and the projected-measurement vector z = Qᵀy. It solves U·x = z by back substitution for the current support size n = current_i+1, and writes coefficient vector x to the X BRAM for residual update and reconstruction. It is started by the top-level controller after done_b of each iteration.

Parameters:
DATA_W, 32, signed fixed-point word width for U, z and x.
FRAC, 16, fractional bits (Q16.16).
MAX_I_W, 5, width of iteration index; max support 2^MAX_I_W = 32.
GUARD, 8, extra accumulator guard bits.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
start_c  in  1  one-cycle start pulse; sampled only in IDLE.
current_i  in  MAX_I_W  last written U column; n = current_i+1; latched on start_c.
u_addr  out  2*MAX_I_W  U BRAM read address = {col, row}, same layout Block B writes.
u_rdata  in  DATA_W  U BRAM data, valid 1 cycle after u_addr.
z_addr  out  MAX_I_W  z BRAM read address.
z_rdata  in  DATA_W  z data, valid 1 cycle after z_addr.
x_we  out  1  X BRAM write enable, one cycle per coefficient.
x_addr  out  MAX_I_W  X BRAM write address.
x_wdata  out  DATA_W  coefficient value.
busy  out  1  high from the cycle after an accepted start_c until done_c.
done_c  out  1  one-cycle completion pulse.
div_err  out  1  sticky divide-by-zero flag; cleared on an accepted start_c.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; u_addr, z_addr, x_addr, x_wdata = 0; x_we, busy, done_c, div_err = 0. Internal x register file is not cleared.
- States: IDLE, Z_RD, Z_LD, MAC_RD, MAC_ACC, D_RD, DIV, WR, DONE.
- IDLE: on start_c, latch n, set k=n-1, clear div_err, go to Z_RD. A start_c in any other state is ignored.
- Z_RD (1 cycle): z_addr=k. Z_LD (1 cycle): acc = sign-extended z_rdata; j=k+1. If j<n go to MAC_RD, else go to D_RD.
- MAC_RD (1 cycle): u_addr={j,k}, i.e. U[k,j]. MAC_ACC (1 cycle): acc -= (u_rdata * xreg[j]) >>> FRAC, using a full 2*DATA_W product with arithmetic shift (truncation toward −inf); j++. Loop back to MAC_RD while j<n, else go to D_RD.
- D_RD (2 cycles): u_addr={k,k}, capture divisor r_kk.
- DIV (DATA_W+FRAC = 48 cycles): sequential restoring signed divide, q = (acc << FRAC) / r_kk, quotient truncated toward zero. If r_kk==0: q=0, set div_err, still spend 48 cycles.
- WR (1 cycle): saturate q to DATA_W range; x_we=1, x_addr=k, x_wdata=q; xreg[k]=q. If k==0 go to DONE, else k-- and go to Z_RD.
- DONE: done_c=1 for exactly one cycle, busy=0, return to IDLE.
- Row latency: 2 + 2*(n-1-k) + 2 + 48 + 1 cycles. Total from start_c to done_c is the sum over rows plus 2. For n=1 this is 55 cycles.
- x writes occur in descending address order, one per row.
- The accumulator is DATA_W+FRAC+GUARD bits wide with no intermediate saturation.
- Reset mid-operation aborts immediately. No x_we is issued after rst_n is asserted.

Test Plan:
- n=1 (current_i=0): U[0,0]=0x00020000 (2.0), z[0]=0x00030000 (3.0) → single write x[0]=0x00018000; done_c at cycle 55 after start_c; div_err=0.
- n=2: U[0,0]=2.0, U[0,1]=1.0, U[1,1]=4.0, z=[5.0, 8.0] → writes x[1]=0x00020000 then x[0]=0x00018000, in that order.
- Negative and saturation: U[0,0]=0xFFFE0000 (−2.0), z[0]=3.0 → x[0]=0xFFFE8000. Separately, U[0,0]=0x00000001, z[0]=0x7FFF0000 → x[0]=0x7FFFFFFF (saturated).
- Divide-by-zero: n=2 with U[1,1]=0 → x[1]=0, div_err=1 held after done_c. div_err clears on the next start_c.
- start_c pulsed mid-run (n=3, during DIV) → ignored: exactly 3 x_we pulses and one done_c.
- rst_n pulsed low during MAC of an n=3 run → all outputs zero asynchronously, no further x_we. A fresh start_c afterwards completes normally.
